ps2_key_fifo: RTL and testbench
===============================

Name: ps2_key_fifo

Overview:
- Downstream consumer of the PS/2 byte receiver. Takes the raw scan-code byte stream (one-cycle valid pulse per received byte) and decodes set-2 prefixes (E0 extended, F0 break) into key events.
- Optionally suppresses typematic auto-repeat.
- Buffers events in a first-word-fall-through FIFO read by the keyboard MMIO device model.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- FILTER_REPEAT, 1, 1 = drop repeated make of the currently held key; 0 = pass every make.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- scan_valid  input  1  one-cycle pulse: scan_code holds a received byte
- scan_code  input  8  raw scan byte
- rd_en  input  1  pop request from consumer
- rd_valid  output  1  FIFO non-empty; rd_data is valid
- rd_data  output  10  {keydown, ext, code[7:0]} of head entry
- count  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky: an event was dropped because the FIFO was full
- clr_ovf  input  1  synchronous clear of overflow

Behaviour:
Reset (reset=0, async):
- Decoder state = IDLE; held-key register invalid; FIFO pointers and count = 0.
- rd_valid=0, rd_data=0, count=0, overflow=0.

Decoder FSM (advances only on cycles with scan_valid=1):
- IDLE: E0 -> EXT; F0 -> BRK; other byte -> emit make {1,0,byte}, stay IDLE.
- EXT: F0 -> EXT_BRK; E0 -> EXT; other byte -> emit make {1,1,byte}, go IDLE.
- BRK: F0 -> BRK (duplicate ignored); E0 -> EXT (resync); other byte -> emit break {0,0,byte}, go IDLE.
- EXT_BRK: F0 -> EXT_BRK; E0 -> EXT; other byte -> emit break {0,1,byte}, go IDLE.
- E1 and all other bytes are treated as ordinary codes. No timeout; a prefix waits indefinitely.

Repeat filter (FILTER_REPEAT=1):
- Held register holds {ext, code} plus a valid bit.
- Make equal to the valid held key: not pushed.
- Any other make: pushed, and held := that key.
- Break matching the held key: pushed, and held invalidated.
- Break not matching the held key: pushed, held unchanged.
- FILTER_REPEAT=0: every emitted event is pushed; the held register is unused.

Latency:
- Final byte's scan_valid in cycle N -> entry written at the edge ending cycle N.
- rd_valid=1 and rd_data valid in cycle N+1 (if the FIFO was empty).

FIFO:
- First-word-fall-through: rd_data = head entry whenever rd_valid=1. rd_data is don't-care when empty, and must not be X after reset.
- Pop occurs at the edge where rd_en=1 and rd_valid=1. rd_en while empty is ignored.
- Push when count<DEPTH.
- Push when count==DEPTH and pop in the same cycle: push accepted, count stays DEPTH, order preserved.
- Push when count==DEPTH and no pop: event dropped, overflow:=1.
- Push and pop in the same cycle with 0<count<DEPTH: count unchanged.
- Push into an empty FIFO with rd_en=1 in the same cycle: no pop (rd_valid was 0); entry visible next cycle.
- Pointers wrap modulo DEPTH.
- overflow clears on clr_ovf=1. If a drop and clr_ovf occur in the same cycle, the drop wins (overflow=1).
- Reset mid-sequence (e.g. after E0 F0): all state discarded; the next byte decodes from IDLE.

Test Plan:
- Bytes 1C, F0, 1C -> two entries: 0x21C (make 'a'), then 0x01C (break); count 1 then 2.
- E0 75, then E0 F0 75 -> entries 0x375, 0x175; rd_valid rises the cycle after the 75 pulse.
- FILTER_REPEAT=1: 1C, 1C, 1C, F0 1C -> exactly 0x21C, 0x01C. FILTER_REPEAT=0 -> three 0x21C, then 0x01C.
- DEPTH=8 with no reads: push 9 makes 0x15..0x1D -> count=8, overflow=1, head 0x215, 0x21D lost; clr_ovf -> overflow=0.
- Full FIFO, push with rd_en=1 in the same cycle -> count stays 8, new entry becomes the last popped; rd_en on empty -> count stays 0, no underflow.
- Send E0 F0, pulse reset low mid-cycle (asynchronously), then send 1C -> outputs 0 immediately, single entry 0x21C.

Source files
------------

// File: rtl/ps2_key_fifo_if.sv
// Key-event bus between the PS/2 byte receiver, the key FIFO and its MMIO consumer.
// The master modport is the producer/consumer side; the slave modport is the FIFO block.
interface ps2_key_fifo_if #(
    parameter int DEPTH = 8
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          scan_valid;
    logic [7:0]    scan_code;
    logic          rd_en;
    logic          clr_ovf;
    logic          rd_valid;
    logic [9:0]    rd_data;
    logic [CW-1:0] count;
    logic          overflow;

    modport master (
        output scan_valid, scan_code, rd_en, clr_ovf,
        input  rd_valid, rd_data, count, overflow
    );

    modport slave (
        input  scan_valid, scan_code, rd_en, clr_ovf,
        output rd_valid, rd_data, count, overflow
    );
endinterface

// File: rtl/ps2_key_fifo.sv
// Set-2 scan-code prefix decoder with optional typematic-repeat filter feeding a
// first-word-fall-through key-event FIFO ({keydown, ext, code}).
//
// state     | meaning
// ----------+------------------------------------------
// S_IDLE    | no prefix pending
// S_EXT     | E0 seen, next code is an extended make
// S_BRK     | F0 seen, next code is a break
// S_EXT_BRK | E0 F0 seen, next code is an extended break
module ps2_key_fifo #(
    parameter int DEPTH         = 8,
    parameter int FILTER_REPEAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    ps2_key_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t        state_q;
    logic          held_vld_q;
    logic [8:0]    held_q;
    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          ovf_q;

    logic          is_e0;
    logic          is_f0;
    logic          emit;
    logic          ev_ext;
    logic          ev_brk;
    logic [8:0]    ev_key;
    logic [9:0]    ev_data;
    logic          held_hit;
    logic          filt_drop;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_ok;
    logic          drop;

    always_comb begin
        is_e0     = (bus.scan_code == 8'hE0);
        is_f0     = (bus.scan_code == 8'hF0);
        emit      = bus.scan_valid && !is_e0 && !is_f0;
        ev_ext    = (state_q == S_EXT) || (state_q == S_EXT_BRK);
        ev_brk    = (state_q == S_BRK) || (state_q == S_EXT_BRK);
        ev_key    = {ev_ext, bus.scan_code};
        ev_data   = {!ev_brk, ev_key};
        held_hit  = held_vld_q && (held_q == ev_key);
        filt_drop = (FILTER_REPEAT != 0) && !ev_brk && held_hit;
        push      = emit && !filt_drop;
        pop       = bus.rd_en && (count_q != '0);
        full      = (count_q == FULL);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        wr_ok     = push && (!full || pop);
        drop      = push && full && !pop;
        count_d   = count_q + {{(CW-1){1'b0}}, wr_ok} - {{(CW-1){1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else if (bus.scan_valid) begin
            case (state_q)
                S_IDLE:    state_q <= is_e0 ? S_EXT : (is_f0 ? S_BRK : S_IDLE);
                S_EXT:     state_q <= is_e0 ? S_EXT : (is_f0 ? S_EXT_BRK : S_IDLE);
                S_BRK:     state_q <= is_e0 ? S_EXT : (is_f0 ? S_BRK : S_IDLE);
                S_EXT_BRK: state_q <= is_e0 ? S_EXT : (is_f0 ? S_EXT_BRK : S_IDLE);
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    // Held key tracks the last accepted make, even if the FIFO itself dropped it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_vld_q <= 1'b0;
            held_q     <= '0;
        end else if ((FILTER_REPEAT != 0) && emit) begin
            if (!ev_brk && !held_hit) begin
                held_vld_q <= 1'b1;
                held_q     <= ev_key;
            end else if (ev_brk && held_hit) begin
                held_vld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= ev_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Head is gated so the uninitialised storage never shows after reset.
    assign bus.rd_valid = (count_q != '0);
    assign bus.rd_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: one instance with the repeat filter, one without,
// both fed the same byte stream.
module tb_ps2_key_fifo;
    logic clk;
    logic rst_n;
    int   vec;
    int   errs;

    ps2_key_fifo_if #(.DEPTH(8)) bus1 ();
    ps2_key_fifo_if #(.DEPTH(8)) bus0 ();

    ps2_key_fifo #(.DEPTH(8), .FILTER_REPEAT(1)) dut1 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus1.slave)
    );

    ps2_key_fifo #(.DEPTH(8), .FILTER_REPEAT(0)) dut0 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus0.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sv, input logic [7:0] code, input logic rd, input logic clr);
        bus1.scan_valid = sv;   bus0.scan_valid = sv;
        bus1.scan_code  = code; bus0.scan_code  = code;
        bus1.rd_en      = rd;   bus0.rd_en      = rd;
        bus1.clr_ovf    = clr;  bus0.clr_ovf    = clr;
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic pop();
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        vec++; if (bus1.rd_valid !== 1'b0) begin errs++; $display("FAIL reset_rd_valid: got %b expected 0", bus1.rd_valid); end
        vec++; if (bus1.rd_data !== 10'h000) begin errs++; $display("FAIL reset_rd_data: got %h expected 000", bus1.rd_data); end
        vec++; if (bus1.count !== 4'd0) begin errs++; $display("FAIL reset_count: got %0d expected 0", bus1.count); end
        vec++; if (bus1.overflow !== 1'b0) begin errs++; $display("FAIL reset_overflow: got %b expected 0", bus1.overflow); end
        vec++; if (bus0.count !== 4'd0) begin errs++; $display("FAIL reset_count_nf: got %0d expected 0", bus0.count); end
    endtask

    task automatic test_make_break();
        send(8'h1C);
        vec++; if (bus1.count !== 4'd1) begin errs++; $display("FAIL mb_count1: got %0d expected 1", bus1.count); end
        vec++; if (bus1.rd_data !== 10'h21C) begin errs++; $display("FAIL mb_make: got %h expected 21c", bus1.rd_data); end
        send(8'hF0);
        vec++; if (bus1.count !== 4'd1) begin errs++; $display("FAIL mb_prefix_count: got %0d expected 1", bus1.count); end
        send(8'h1C);
        vec++; if (bus1.count !== 4'd2) begin errs++; $display("FAIL mb_count2: got %0d expected 2", bus1.count); end
        pop();
        vec++; if (bus1.rd_data !== 10'h01C) begin errs++; $display("FAIL mb_break: got %h expected 01c", bus1.rd_data); end
        pop();
        vec++; if (bus1.count !== 4'd0) begin errs++; $display("FAIL mb_drain: got %0d expected 0", bus1.count); end
        vec++; if (bus0.count !== 4'd0) begin errs++; $display("FAIL mb_drain_nf: got %0d expected 0", bus0.count); end
    endtask

    task automatic test_extended();
        send(8'hE0);
        vec++; if (bus1.rd_valid !== 1'b0) begin errs++; $display("FAIL ext_prefix_valid: got %b expected 0", bus1.rd_valid); end
        drive(1'b1, 8'h75, 1'b0, 1'b0);
        #1;
        vec++; if (bus1.rd_valid !== 1'b0) begin errs++; $display("FAIL ext_same_cycle_valid: got %b expected 0", bus1.rd_valid); end
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        vec++; if (bus1.rd_valid !== 1'b1) begin errs++; $display("FAIL ext_next_cycle_valid: got %b expected 1", bus1.rd_valid); end
        vec++; if (bus1.rd_data !== 10'h375) begin errs++; $display("FAIL ext_make: got %h expected 375", bus1.rd_data); end
        send(8'hE0); send(8'hF0); send(8'h75);
        vec++; if (bus1.count !== 4'd2) begin errs++; $display("FAIL ext_count: got %0d expected 2", bus1.count); end
        pop();
        vec++; if (bus1.rd_data !== 10'h175) begin errs++; $display("FAIL ext_break: got %h expected 175", bus1.rd_data); end
        pop();
    endtask

    task automatic test_repeat();
        logic [9:0] exp1 [2];
        logic [9:0] exp0 [4];
        exp1[0] = 10'h21C; exp1[1] = 10'h01C;
        exp0[0] = 10'h21C; exp0[1] = 10'h21C; exp0[2] = 10'h21C; exp0[3] = 10'h01C;
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        vec++; if (bus1.count !== 4'd2) begin errs++; $display("FAIL rep_count_filt: got %0d expected 2", bus1.count); end
        vec++; if (bus0.count !== 4'd4) begin errs++; $display("FAIL rep_count_nofilt: got %0d expected 4", bus0.count); end
        for (int i = 0; i < 4; i++) begin
            if (i < 2) begin
                vec++; if (bus1.rd_data !== exp1[i]) begin errs++; $display("FAIL rep_filt_%0d: got %h expected %h", i, bus1.rd_data, exp1[i]); end
            end
            vec++; if (bus0.rd_data !== exp0[i]) begin errs++; $display("FAIL rep_nofilt_%0d: got %h expected %h", i, bus0.rd_data, exp0[i]); end
            pop();
        end
        vec++; if (bus1.count !== 4'd0) begin errs++; $display("FAIL rep_underflow: got %0d expected 0", bus1.count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) send(8'h15 + 8'(i));
        vec++; if (bus1.overflow !== 1'b0) begin errs++; $display("FAIL ovf_at_full: got %b expected 0", bus1.overflow); end
        send(8'h1D);
        vec++; if (bus1.count !== 4'd8) begin errs++; $display("FAIL ovf_count: got %0d expected 8", bus1.count); end
        vec++; if (bus1.overflow !== 1'b1) begin errs++; $display("FAIL ovf_set: got %b expected 1", bus1.overflow); end
        vec++; if (bus1.rd_data !== 10'h215) begin errs++; $display("FAIL ovf_head: got %h expected 215", bus1.rd_data); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        vec++; if (bus1.overflow !== 1'b0) begin errs++; $display("FAIL ovf_clear: got %b expected 0", bus1.overflow); end
        drive(1'b1, 8'h1E, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        vec++; if (bus1.overflow !== 1'b1) begin errs++; $display("FAIL ovf_drop_beats_clr: got %b expected 1", bus1.overflow); end
        vec++; if (bus0.overflow !== 1'b1) begin errs++; $display("FAIL ovf_drop_beats_clr_nf: got %b expected 1", bus0.overflow); end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        vec++; if (bus1.overflow !== 1'b0) begin errs++; $display("FAIL ovf_clear2: got %b expected 0", bus1.overflow); end
    endtask

    task automatic test_full_push_pop();
        drive(1'b1, 8'h2E, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        vec++; if (bus1.count !== 4'd8) begin errs++; $display("FAIL fpp_count: got %0d expected 8", bus1.count); end
        vec++; if (bus1.overflow !== 1'b0) begin errs++; $display("FAIL fpp_no_ovf: got %b expected 0", bus1.overflow); end
        for (int k = 0; k < 7; k++) begin
            vec++;
            if (bus1.rd_data !== {2'b10, 8'h16 + 8'(k)}) begin
                errs++; $display("FAIL fpp_order_%0d: got %h expected %h", k, bus1.rd_data, {2'b10, 8'h16 + 8'(k)});
            end
            pop();
        end
        vec++; if (bus1.rd_data !== 10'h22E) begin errs++; $display("FAIL fpp_last: got %h expected 22e", bus1.rd_data); end
        vec++; if (bus0.rd_data !== 10'h22E) begin errs++; $display("FAIL fpp_last_nf: got %h expected 22e", bus0.rd_data); end
        pop();
        vec++; if (bus1.count !== 4'd0) begin errs++; $display("FAIL fpp_empty: got %0d expected 0", bus1.count); end
        pop();
        vec++; if (bus1.count !== 4'd0) begin errs++; $display("FAIL empty_pop_count: got %0d expected 0", bus1.count); end
        vec++; if (bus1.rd_valid !== 1'b0) begin errs++; $display("FAIL empty_pop_valid: got %b expected 0", bus1.rd_valid); end
        drive(1'b1, 8'h33, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        vec++; if (bus1.count !== 4'd1) begin errs++; $display("FAIL empty_push_rd_count: got %0d expected 1", bus1.count); end
        vec++; if (bus1.rd_data !== 10'h233) begin errs++; $display("FAIL empty_push_rd_data: got %h expected 233", bus1.rd_data); end
        pop();
    endtask

    task automatic test_reset_mid();
        send(8'h44); send(8'hE0); send(8'hF0);
        vec++; if (bus1.count !== 4'd1) begin errs++; $display("FAIL rmid_pre_count: got %0d expected 1", bus1.count); end
        #2 rst_n = 1'b0;
        #1;
        vec++; if (bus1.count !== 4'd0) begin errs++; $display("FAIL rmid_count: got %0d expected 0", bus1.count); end
        vec++; if (bus1.rd_valid !== 1'b0) begin errs++; $display("FAIL rmid_valid: got %b expected 0", bus1.rd_valid); end
        vec++; if (bus1.rd_data !== 10'h000) begin errs++; $display("FAIL rmid_data: got %h expected 000", bus1.rd_data); end
        #1 rst_n = 1'b1;
        step();
        send(8'h1C);
        vec++; if (bus1.count !== 4'd1) begin errs++; $display("FAIL rmid_post_count: got %0d expected 1", bus1.count); end
        vec++; if (bus1.rd_data !== 10'h21C) begin errs++; $display("FAIL rmid_post_data: got %h expected 21c", bus1.rd_data); end
        vec++; if (bus0.rd_data !== 10'h21C) begin errs++; $display("FAIL rmid_post_data_nf: got %h expected 21c", bus0.rd_data); end
    endtask

    initial begin
        vec   = 0;
        errs  = 0;
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_make_break();
        test_extended();
        test_repeat();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
